memory_port_arbiter: RTL and testbench

- Command front-end for the single-port MEMORY block.
- Accepts one write client and two read clients (A, B), each with a req/ack handshake.
- Arbitrates so that at most one of write / read-to-a / read-to-b strobes the memory per cycle, and drives the memory's command inputs.
- Produces read-valid strobes aligned with the memory's registered oDataOuta / oDataOutb, so downstream consumers sample only valid data.

---
 rtl/memory_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Command front-end for the single-port MEMORY: arbitrates one write and two read clients with
// rotating priority and produces read-valid strobes aligned with the memory's registered outputs.
module memory_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_SIZE   = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iWrReq,
    input  logic [ADDR_WIDTH-1:0] iWrAddr,
    input  logic [DATA_WIDTH-1:0] iWrData,
    output logic                  oWrAck,
    input  logic                  iRdReqA,
    input  logic [ADDR_WIDTH-1:0] iRdAddrA,
    output logic                  oRdAckA,
    input  logic                  iRdReqB,
    input  logic [ADDR_WIDTH-1:0] iRdAddrB,
    output logic                  oRdAckB,
    output logic                  oMemWriteEnable,
    output logic                  oMemReadtoa,
    output logic                  oMemReadtob,
    output logic [ADDR_WIDTH-1:0] oMemAddress,
    output logic [DATA_WIDTH-1:0] oMemDataIn,
    output logic                  oRdValidA,
    output logic                  oRdValidB,
    output logic                  oErr
);

    localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MEM_SIZE);

    // Pointer names the client that has highest priority at the next edge.
    typedef enum logic [1:0] {
        PtrW = 2'd0,
        PtrA = 2'd1,
        PtrB = 2'd2
    } ptr_e;

    ptr_e                  ptr_q, ptr_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  rd_ack_a_q, rd_ack_a_d;
    logic                  rd_ack_b_q, rd_ack_b_d;
    logic                  we_q, we_d;
    logic                  rd_a_q, rd_a_d;
    logic                  rd_b_q, rd_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic elig_w, elig_a, elig_b;
    logic gnt_w, gnt_a, gnt_b;
    logic oor_w, oor_a, oor_b;

    // A client acked this cycle is still holding req; mask it so it cannot be granted twice.
    assign elig_w = iWrReq  & ~wr_ack_q;
    assign elig_a = iRdReqA & ~rd_ack_a_q;
    assign elig_b = iRdReqB & ~rd_ack_b_q;

    assign oor_w = (iWrAddr  > MaxAddr);
    assign oor_a = (iRdAddrA > MaxAddr);
    assign oor_b = (iRdAddrB > MaxAddr);

    always_comb begin
        gnt_w = 1'b0;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        case (ptr_q)
            PtrA: begin
                if (elig_a)      gnt_a = 1'b1;
                else if (elig_b) gnt_b = 1'b1;
                else if (elig_w) gnt_w = 1'b1;
            end
            PtrB: begin
                if (elig_b)      gnt_b = 1'b1;
                else if (elig_w) gnt_w = 1'b1;
                else if (elig_a) gnt_a = 1'b1;
            end
            default: begin
                if (elig_w)      gnt_w = 1'b1;
                else if (elig_a) gnt_a = 1'b1;
                else if (elig_b) gnt_b = 1'b1;
            end
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        wr_ack_d   = 1'b0;
        rd_ack_a_d = 1'b0;
        rd_ack_b_d = 1'b0;
        we_d       = 1'b0;
        rd_a_d     = 1'b0;
        rd_b_d     = 1'b0;
        err_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        // Memory data is registered, so valid trails the read strobe by exactly one cycle.
        valid_a_d  = rd_a_q;
        valid_b_d  = rd_b_q;

        if (gnt_w) begin
            wr_ack_d = 1'b1;
            we_d     = ~oor_w;
            err_d    = oor_w;
            addr_d   = iWrAddr;
            data_d   = iWrData;
            ptr_d    = PtrA;
        end else if (gnt_a) begin
            rd_ack_a_d = 1'b1;
            rd_a_d     = ~oor_a;
            err_d      = oor_a;
            addr_d     = iRdAddrA;
            ptr_d      = PtrB;
        end else if (gnt_b) begin
            rd_ack_b_d = 1'b1;
            rd_b_d     = ~oor_b;
            err_d      = oor_b;
            addr_d     = iRdAddrB;
            ptr_d      = PtrW;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ptr_q      <= PtrW;
            wr_ack_q   <= 1'b0;
            rd_ack_a_q <= 1'b0;
            rd_ack_b_q <= 1'b0;
            we_q       <= 1'b0;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_a_q <= rd_ack_a_d;
            rd_ack_b_q <= rd_ack_b_d;
            we_q       <= we_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign oWrAck          = wr_ack_q;
    assign oRdAckA         = rd_ack_a_q;
    assign oRdAckB         = rd_ack_b_q;
    assign oMemWriteEnable = we_q;
    assign oMemReadtoa     = rd_a_q;
    assign oMemReadtob     = rd_b_q;
    assign oMemAddress     = addr_q;
    assign oMemDataIn      = data_q;
    assign oRdValidA       = valid_a_q;
    assign oRdValidB       = valid_b_q;
    assign oErr            = err_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and read data; a negedge monitor checks them.
module tb_memory_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int MS = 10;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iWrReq = 1'b0;
    logic [AW-1:0] iWrAddr = '0;
    logic [DW-1:0] iWrData = '0;
    logic          iRdReqA = 1'b0;
    logic [AW-1:0] iRdAddrA = '0;
    logic          iRdReqB = 1'b0;
    logic [AW-1:0] iRdAddrB = '0;
    logic          oWrAck, oRdAckA, oRdAckB;
    logic          oMemWriteEnable, oMemReadtoa, oMemReadtob;
    logic [AW-1:0] oMemAddress;
    logic [DW-1:0] oMemDataIn;
    logic          oRdValidA, oRdValidB, oErr;

    always #5 Clock = ~Clock;

    memory_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_SIZE  (MS)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iWrReq         (iWrReq),
        .iWrAddr        (iWrAddr),
        .iWrData        (iWrData),
        .oWrAck         (oWrAck),
        .iRdReqA        (iRdReqA),
        .iRdAddrA       (iRdAddrA),
        .oRdAckA        (oRdAckA),
        .iRdReqB        (iRdReqB),
        .iRdAddrB       (iRdAddrB),
        .oRdAckB        (oRdAckB),
        .oMemWriteEnable(oMemWriteEnable),
        .oMemReadtoa    (oMemReadtoa),
        .oMemReadtob    (oMemReadtob),
        .oMemAddress    (oMemAddress),
        .oMemDataIn     (oMemDataIn),
        .oRdValidA      (oRdValidA),
        .oRdValidB      (oRdValidB),
        .oErr           (oErr)
    );

    // Behavioural single-port memory with registered read outputs.
    logic [DW-1:0] mem [0:MS];
    logic [DW-1:0] douta, doutb;
    always @(posedge Clock) begin
        if (oMemWriteEnable && oMemAddress <= AW'(MS)) mem[oMemAddress] <= oMemDataIn;
        if (oMemReadtoa) douta <= (oMemAddress <= AW'(MS)) ? mem[oMemAddress] : 'x;
        if (oMemReadtob) doutb <= (oMemAddress <= AW'(MS)) ? mem[oMemAddress] : 'x;
    end

    typedef struct packed {
        logic [1:0]    kind;  // 0 write, 1 read A, 2 read B
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } grant_t;

    grant_t        gq[$];
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int            tests = 0;
    int            fails = 0;
    logic          rst_at_edge = 1'b0;

    always @(posedge Clock) rst_at_edge <= Reset;

    function automatic void exp_grant(input int k, input int a, input int d);
        grant_t g;
        g.kind = 2'(k);
        g.addr = AW'(a);
        g.data = DW'(d);
        gq.push_back(g);
    endfunction

    // Monitor: checks every cycle against the scoreboard queues.
    initial begin : monitor
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_data;
        logic [26:0]   act_r, exp_r;
        logic [24:0]   act, expv;
        logic          err;
        grant_t        g;
        logic [DW-1:0] d;
        last_addr = '0;
        last_data = '0;
        forever begin
            @(negedge Clock);
            if (!rst_at_edge) begin
                tests++;
                act_r = {oWrAck, oRdAckA, oRdAckB, oMemWriteEnable, oMemReadtoa, oMemReadtob,
                         oRdValidA, oRdValidB, oErr, oMemAddress, oMemDataIn};
                exp_r = '0;
                if (act_r !== exp_r) begin
                    fails++;
                    $display("FAIL reset_clear: got %h want %h", act_r, exp_r);
                end
                last_addr = '0;
                last_data = '0;
            end else begin
                act = {oWrAck, oRdAckA, oRdAckB, oMemWriteEnable, oMemReadtoa, oMemReadtob,
                       oErr, oMemAddress, oMemDataIn};
                if (oWrAck || oRdAckA || oRdAckB) begin
                    tests++;
                    if (gq.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_grant: got %h want no grant", act);
                    end else begin
                        g    = gq.pop_front();
                        err  = (g.addr > AW'(MS));
                        expv = {g.kind == 2'd0, g.kind == 2'd1, g.kind == 2'd2,
                                g.kind == 2'd0 && !err, g.kind == 2'd1 && !err,
                                g.kind == 2'd2 && !err, err, g.addr,
                                (g.kind == 2'd0) ? g.data : last_data};
                        if (act !== expv) begin
                            fails++;
                            $display("FAIL grant: got %h want %h", act, expv);
                        end
                        last_addr = g.addr;
                        if (g.kind == 2'd0) last_data = g.data;
                    end
                end else begin
                    tests++;
                    expv = {7'b0, last_addr, last_data};
                    if (act !== expv) begin
                        fails++;
                        $display("FAIL idle_hold: got %h want %h", act, expv);
                    end
                end
                if (oRdValidA) begin
                    tests++;
                    if (qa.size() == 0) begin
                        fails++;
                        $display("FAIL valid_a: got unexpected valid want none");
                    end else begin
                        d = qa.pop_front();
                        if (douta !== d) begin
                            fails++;
                            $display("FAIL data_a: got %h want %h", douta, d);
                        end
                    end
                end
                if (oRdValidB) begin
                    tests++;
                    if (qb.size() == 0) begin
                        fails++;
                        $display("FAIL valid_b: got unexpected valid want none");
                    end else begin
                        d = qb.pop_front();
                        if (doutb !== d) begin
                            fails++;
                            $display("FAIL data_b: got %h want %h", doutb, d);
                        end
                    end
                end
            end
        end
    end

    function automatic logic ack_of(input int k);
        return (k == 0) ? oWrAck : (k == 1) ? oRdAckA : oRdAckB;
    endfunction

    task automatic drop_req(input int k);
        if (k == 0) iWrReq = 1'b0;
        else if (k == 1) iRdReqA = 1'b0;
        else iRdReqB = 1'b0;
    endtask

    // Wait (bounded) for client k's ack, then release its request.
    task automatic wait_drop(input int k);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (ack_of(k)) seen = 1'b1;
        end
        drop_req(k);
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: client %0d got no ack want ack", k);
        end
    endtask

    task automatic do_req(input int k, input int a, input int d);
        @(negedge Clock);
        if (k == 0) begin
            iWrAddr = AW'(a);
            iWrData = DW'(d);
            iWrReq  = 1'b1;
        end else if (k == 1) begin
            iRdAddrA = AW'(a);
            iRdReqA  = 1'b1;
        end else begin
            iRdAddrB = AW'(a);
            iRdReqB  = 1'b1;
        end
        wait_drop(k);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic seen;
        // Reset with all three requests high; after release grants must be W, A, B.
        iWrAddr  = AW'(1);
        iWrData  = 8'h11;
        iRdAddrA = AW'(1);
        iRdAddrB = AW'(1);
        iWrReq   = 1'b1;
        iRdReqA  = 1'b1;
        iRdReqB  = 1'b1;
        exp_grant(0, 1, 8'h11);
        exp_grant(1, 1, 0);
        exp_grant(2, 1, 0);
        qa.push_back(8'h11);
        qb.push_back(8'h11);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        fork
            wait_drop(0);
            wait_drop(1);
            wait_drop(2);
        join
        repeat (3) @(negedge Clock);

        // Write then read back through client A.
        exp_grant(0, 3, 8'hA5);
        exp_grant(1, 3, 0);
        qa.push_back(8'hA5);
        do_req(0, 3, 8'hA5);
        do_req(1, 3, 0);
        repeat (3) @(negedge Clock);

        // A and B held high for 8 cycles; a write joins after the 4th grant.
        exp_grant(2, 1, 0);
        exp_grant(1, 3, 0);
        exp_grant(2, 1, 0);
        exp_grant(1, 3, 0);
        exp_grant(2, 1, 0);
        exp_grant(0, 5, 8'h5C);
        exp_grant(1, 3, 0);
        exp_grant(2, 1, 0);
        repeat (3) qa.push_back(8'hA5);
        repeat (4) qb.push_back(8'h11);
        @(negedge Clock);
        iRdAddrA = AW'(3);
        iRdAddrB = AW'(1);
        iRdReqA  = 1'b1;
        iRdReqB  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            if (oWrAck) iWrReq = 1'b0;
            if (k == 4) begin
                iWrAddr = AW'(5);
                iWrData = 8'h5C;
                iWrReq  = 1'b1;
            end
        end
        iWrReq  = 1'b0;
        iRdReqA = 1'b0;
        iRdReqB = 1'b0;
        repeat (3) @(negedge Clock);

        // Out-of-range write and read; boundary address MEM_SIZE; contents intact.
        exp_grant(0, 11, 8'hFF);
        exp_grant(2, 12, 0);
        exp_grant(0, 10, 8'h3C);
        exp_grant(1, 10, 0);
        exp_grant(2, 5, 0);
        exp_grant(1, 3, 0);
        qa.push_back(8'h3C);
        qb.push_back(8'h5C);
        qa.push_back(8'hA5);
        do_req(0, 11, 8'hFF);
        do_req(2, 12, 0);
        do_req(0, 10, 8'h3C);
        do_req(1, 10, 0);
        do_req(2, 5, 0);
        do_req(1, 3, 0);
        repeat (3) @(negedge Clock);

        // Reset asserted during the read-B strobe cycle: no read-valid may follow.
        exp_grant(2, 5, 0);
        @(negedge Clock);
        iRdAddrB = AW'(5);
        iRdReqB  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (oRdAckB) seen = 1'b1;
        end
        iRdReqB = 1'b0;
        Reset   = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: read B got no ack want ack");
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Recovery after reset.
        exp_grant(0, 2, 8'h77);
        exp_grant(2, 2, 0);
        qb.push_back(8'h77);
        do_req(0, 2, 8'h77);
        do_req(2, 2, 0);
        repeat (4) @(negedge Clock);

        tests++;
        if (gq.size() != 0) begin
            fails++;
            $display("FAIL grants_left: got %0d want 0", gq.size());
        end
        tests++;
        if (qa.size() != 0) begin
            fails++;
            $display("FAIL reads_a_left: got %0d want 0", qa.size());
        end
        tests++;
        if (qb.size() != 0) begin
            fails++;
            $display("FAIL reads_b_left: got %0d want 0", qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
